// File: rtl/config_loader.sv
// Fabric configuration loader: streams bitstream words LSB-first into a serial
// config chain, then sequences fabric reset release and register enable.
module config_loader #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 17
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  cfg_shift,
  output logic                  cfg_bit,
  output logic                  fabric_nreset,
  output logic                  fabric_enable,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            fsm_state
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        remaining, remaining_n;  // bits still to shift into the chain
  logic [CNT_W-1:0]        uncovered, uncovered_n;  // bits not yet covered by an accepted word
  logic [BIT_W-1:0]        held, held_n;            // valid bits left in the shifter
  logic [DATA_WIDTH-1:0]   shifter, shifter_n;
  logic [BIT_W-1:0]        word_bits;
  logic                    accept;

  // Handshake: a word moves only on a rising edge where s_valid and s_ready are
  // both high. s_ready never depends on s_valid; the sender may hold s_valid
  // high indefinitely. Ready rises while the last held bit is still shifting so
  // consecutive words produce an unbroken cfg_shift stream.
  assign s_ready   = (state == LOAD) && (uncovered != '0) && (held <= BIT_W'(1));
  assign accept    = s_valid && s_ready;
  assign fsm_state = state;

  always_comb begin
    word_bits = BIT_W'(DATA_WIDTH);
    if (32'(uncovered) < DATA_WIDTH) word_bits = BIT_W'(uncovered);
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    uncovered_n = uncovered;
    held_n      = held;
    shifter_n   = shifter;
    case (state)
      IDLE, RUN: begin
        if (start) begin
          state_n     = LOAD;
          remaining_n = CNT_W'(CHAIN_LENGTH);
          uncovered_n = CNT_W'(CHAIN_LENGTH);
          held_n      = '0;
          shifter_n   = '0;
        end
      end
      LOAD: begin
        if (held != '0) begin
          shifter_n   = shifter >> 1;
          held_n      = held - BIT_W'(1);
          remaining_n = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_n = RELEASE;
        end
        // A short final word keeps only its low bits; the rest never shift out.
        if (accept) begin
          shifter_n   = s_data;
          held_n      = word_bits;
          uncovered_n = uncovered - CNT_W'(word_bits);
        end
      end
      RELEASE: state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      uncovered     <= '0;
      held          <= '0;
      shifter       <= '0;
      cfg_shift     <= 1'b0;
      cfg_bit       <= 1'b0;
      fabric_nreset <= 1'b0;
      fabric_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      remaining     <= remaining_n;
      uncovered     <= uncovered_n;
      held          <= held_n;
      shifter       <= shifter_n;
      cfg_shift     <= (held_n != '0);
      cfg_bit       <= (held_n != '0) && shifter_n[0];
      fabric_nreset <= (state_n == RELEASE) || (state_n == RUN);
      fabric_enable <= (state_n == RUN);
      busy          <= (state_n == LOAD) || (state_n == RELEASE);
      done          <= (state_n == RELEASE);
    end
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one bitstream word on the input stream.
REQ-002 Parameter CHAIN_LENGTH, default 17: total bits in the fabric configuration shift chain, at least 1.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request a (re)configuration.
REQ-006 Port s_data, input, DATA_WIDTH: bitstream word, LSB shifted first.
REQ-007 Port s_valid, input, 1: s_data valid.
REQ-008 Port s_ready, output, 1: block accepts s_data this cycle.
REQ-009 Port cfg_shift, output, 1: config chain shifts one bit this cycle.
REQ-010 Port cfg_bit, output, 1: serial bit presented with cfg_shift.
REQ-011 Port fabric_nreset, output, 1: active-low reset to the logic elements.
REQ-012 Port fabric_enable, output, 1: register enable to the logic elements.
REQ-013 Port busy, output, 1: high in LOAD and RELEASE.
REQ-014 Port done, output, 1: one-cycle pulse when configuration completes.

Function
REQ-015 States: IDLE, LOAD, RELEASE, RUN.
REQ-016 IDLE: fabric_nreset=0, fabric_enable=0, s_ready=0, cfg_shift=0; start=1 goes to LOAD.
REQ-017 LOAD: fabric_nreset=0, fabric_enable=0; remaining-bit counter set to CHAIN_LENGTH on entry.
REQ-018 Word transfer occurs only on a cycle with s_valid=1 and s_ready=1.
REQ-019 An accepted word loads a DATA_WIDTH-bit shifter.
REQ-020 From the cycle after acceptance, one bit per cycle leaves the shifter: cfg_shift=1, cfg_bit = shifter bit 0.
REQ-021 Each shifted bit decrements the remaining-bit counter by 1.
REQ-022 Shifting is uninterrupted once a word is accepted; an empty shifter gives cfg_shift=0 and cfg_bit=0.
REQ-023 In LOAD, s_ready=1 when the shifter is empty, or when it is shifting its last valid bit and remaining bits after that shift exceed 0, so back-to-back words stream with no gap cycle.
REQ-024 s_ready=0 once all remaining bits are covered by accepted words.
REQ-025 Final word when CHAIN_LENGTH is not a multiple of DATA_WIDTH: only the low (CHAIN_LENGTH mod DATA_WIDTH) bits are shifted; upper bits are discarded with no cfg_shift.
REQ-026 When the counter reaches 0 (cycle after the last cfg_shift), go to RELEASE.
REQ-027 RELEASE lasts exactly one cycle: fabric_nreset=1, fabric_enable=0, done=1; then RUN.
REQ-028 RUN: fabric_nreset=1, fabric_enable=1, busy=0, s_ready=0.
REQ-029 start=1 in RUN goes to LOAD next cycle; fabric_nreset and fabric_enable drop to 0 that same cycle, and the counter reloads.
REQ-030 start in LOAD or RELEASE is ignored.
REQ-031 s_valid outside LOAD is ignored; no word is consumed.
REQ-032 Stalled s_valid: the block waits indefinitely with cfg_shift=0; no timeout.
REQ-033 All outputs are registered except s_ready, which may be combinational from state, counter and shifter occupancy.

Reset
REQ-034 reset=1 at a clock edge forces IDLE, clears the shifter and counter, and drives s_ready=0, cfg_shift=0, cfg_bit=0, fabric_nreset=0, fabric_enable=0, busy=0, done=0 from the next cycle.
REQ-035 reset overrides start and any transfer in the same cycle.
REQ-036 reset mid-LOAD discards partial configuration; a new start is required.

Verification
REQ-037 Full load (DATA_WIDTH=8, CHAIN_LENGTH=17): start, words 0xA5, 0x3C, 0x01 with continuous s_valid -> 17 consecutive cfg_shift cycles, bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1; done pulses once; then RUN with fabric_enable=1.
REQ-038 Partial last word: final word 0xFF when CHAIN_LENGTH=17 -> exactly 1 cfg_shift for that word; s_ready=0 afterwards.
REQ-039 Backpressure: s_valid drops for 5 cycles between words -> cfg_shift=0 during the gap, no extra bits, total still 17.
REQ-040 Reset mid-load after 9 bits -> next cycle all outputs at reset values; a fresh start plus 3 words gives a correct 17-bit load.
REQ-041 Reconfigure: start in RUN -> fabric_enable=0 and fabric_nreset=0 the next cycle, a second 17-bit load completes, and done pulses again.
REQ-042 Ignored inputs: start in LOAD and s_valid in IDLE/RUN -> no state change and no word consumed.
